// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the instruction fetch sequencer.
// Holds the memory geometry defaults previously kept in constants.vh.
package imem_fetch_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 5;
    localparam int IMEM_DEPTH     = 16;
    localparam int WORD_WIDTH     = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, instruction memory, branch unit and decode.
// master = fetch sequencer, slave = memory/decode/branch side.
interface imem_fetch_ctrl_if
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int WORD_W = WORD_WIDTH
);

    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_inst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc
    );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_buf2.sv
// Two-entry synchronous FIFO; entry 0 is the head and drives dout straight from a register.
// Flush takes precedence over push and pop.
module fetch_buf2
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W = MEM_ADDR_WIDTH + WORD_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        count_q, count_d;
    logic              pop_ok;
    logic              push_ok;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);
        push_ok = push && ((count_q != 2'd2) || pop_ok);

        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = din;
                    else                 ent1_d = din;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Only shift when a second entry exists so an emptied head keeps its last word
                    if (count_q == 2'd2) ent0_d = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = din;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign dout  = ent0_q;
    assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational instruction memory and
// feeds decode through a 2-entry buffer, with redirect flush and start/halt control.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_WIDTH,
    parameter int DEPTH   = IMEM_DEPTH,
    parameter int WORD_W  = WORD_WIDTH,
    parameter int BOOT_PC = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                halt_req,
    output logic                busy,
    imem_fetch_ctrl_if.master   bus
);

    localparam int                DATA_W  = ADDR_W + WORD_W;
    localparam logic [ADDR_W-1:0] BOOT    = ADDR_W'(BOOT_PC);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               run;
    logic               pop;
    logic               fire;
    logic [1:0]         count;
    logic [DATA_W-1:0]  buf_din;
    logic [DATA_W-1:0]  buf_dout;

    // Wrap by explicit compare so DEPTH need not be a power of two
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return (pc == LAST_PC) ? '0 : pc + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] pc_clamp(input logic [ADDR_W-1:0] pc);
        return ({1'b0, pc} >= DEPTH_X) ? '0 : pc;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH_IDLE;
            pc_q    <= BOOT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // halt_req beats a simultaneous start when leaving IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: if (start && !halt_req) state_d = FETCH_RUN;
            FETCH_RUN:  if (halt_req)           state_d = FETCH_HALT;
            FETCH_HALT: if (start)              state_d = FETCH_RUN;
            default:                            state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        run  = (state_q == FETCH_RUN);
        busy = run;
    end

    always_comb begin
        pop  = bus.out_valid && bus.out_ready;
        fire = run && !bus.redirect_valid && ((count != 2'd2) || pop);
        pc_d = pc_q;
        if (bus.redirect_valid) pc_d = pc_clamp(bus.redirect_pc);
        else if (fire)          pc_d = pc_inc(pc_q);
    end

    assign buf_din = {pc_q, bus.imem_inst};

    fetch_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fire),
        .pop     (pop),
        .flush   (bus.redirect_valid),
        .din     (buf_din),
        .dout    (buf_dout),
        .count   (count)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_inst  = buf_dout[WORD_W-1:0];
    assign bus.out_pc    = buf_dout[DATA_W-1:WORD_W];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a scoreboard of expected presented PCs checked on
// every decode handshake, plus cycle-accurate checks of latency, stall, flush, wrap and reset.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

    localparam int AW    = 5;
    localparam int WW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic start, halt_req, busy;
    logic start2, halt2, busy2;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [AW-1:0] exp_q[$];

    imem_fetch_ctrl_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();
    imem_fetch_ctrl_if #(.ADDR_W(AW), .WORD_W(WW)) bus2 ();

    imem_fetch_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .WORD_W(WW), .BOOT_PC(0)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .halt_req (halt_req),
        .busy     (busy),
        .bus      (bus)
    );

    imem_fetch_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .WORD_W(WW), .BOOT_PC(14)) dut2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start2),
        .halt_req (halt2),
        .busy     (busy2),
        .bus      (bus2)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: mem[i] = i + 0x100
    always_comb bus.imem_inst  = 32'h100 + 32'(bus.imem_addr);
    always_comb bus2.imem_inst = 32'h100 + 32'(bus2.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n            = 1'b0;
        start              = 1'b0;
        halt_req           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        exp_q.delete();
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every accepted word must be the next expected PC with its memory word
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                assert (exp_q.size() != 0) else begin
                    tests_failed++;
                    $error("FAIL sb_underflow: observed out_pc=%0d expected no handshake", bus.out_pc);
                end
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", 32'(bus.out_pc), 32'(e));
                chk("sb_inst", bus.out_inst, 32'h100 + 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n             = 1'b1;
        start               = 1'b0;
        halt_req            = 1'b0;
        start2              = 1'b0;
        halt2               = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.out_ready      = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_inst", bus.out_inst, 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_addr2", 32'(bus2.imem_addr), 32'd14);
        chk("rst_busy2", 32'(busy2), 32'd0);

        // Start with decode always ready: one-cycle latency, then one word per cycle
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
        pulse_start();
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_first_valid", 32'(bus.out_valid), 32'd0);
        chk("run_first_addr", 32'(bus.imem_addr), 32'd0);
        step(1);
        chk("run_valid", 32'(bus.out_valid), 32'd1);
        chk("run_pc0", 32'(bus.out_pc), 32'd0);
        chk("run_inst0", bus.out_inst, 32'h100);
        chk("run_addr1", 32'(bus.imem_addr), 32'd1);
        step(1);
        chk("run_pc1", 32'(bus.out_pc), 32'd1);
        chk("run_addr2", 32'(bus.imem_addr), 32'd2);
        drain(20);

        // Backpressure from the start, then halt with a full buffer and resume
        apply_reset();
        pulse_start();
        step(2);
        chk("bp_addr_frozen_a", 32'(bus.imem_addr), 32'd2);
        step(2);
        chk("bp_addr_frozen_b", 32'(bus.imem_addr), 32'd2);
        chk("bp_pc_held", 32'(bus.out_pc), 32'd0);
        chk("bp_inst_held", bus.out_inst, 32'h100);
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
        bus.out_ready = 1'b1;
        drain(10);
        chk("bp_head_after", 32'(bus.out_pc), 32'd4);
        chk("bp_addr_after", 32'(bus.imem_addr), 32'd6);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_valid", 32'(bus.out_valid), 32'd1);
        exp_q.push_back(AW'(4));
        exp_q.push_back(AW'(5));
        bus.out_ready = 1'b1;
        drain(10);
        chk("halt_empty", 32'(bus.out_valid), 32'd0);
        chk("halt_busy2", 32'(busy), 32'd0);
        chk("halt_pc_held", 32'(bus.imem_addr), 32'd6);
        for (int i = 6; i < 9; i++) exp_q.push_back(AW'(i));
        bus.out_ready = 1'b1;
        pulse_start();
        chk("resume_busy", 32'(busy), 32'd1);
        drain(20);

        // start together with halt_req in IDLE keeps the FSM idle
        apply_reset();
        start    = 1'b1;
        halt_req = 1'b1;
        step(1);
        start    = 1'b0;
        halt_req = 1'b0;
        chk("idle_both_busy", 32'(busy), 32'd0);
        step(2);
        chk("idle_both_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_both_addr", 32'(bus.imem_addr), 32'd0);

        // Redirect while PC 3 is presented: 4 and 5 must never reach decode
        apply_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
        for (int i = 9; i < 12; i++) exp_q.push_back(AW'(i));
        bus.out_ready = 1'b1;
        pulse_start();
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                step(1);
                if (bus.out_valid && bus.out_pc == AW'(3)) found = 1'b1;
            end
            chk("redir_wait_pc3", 32'(found), 32'd1);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(9);
        step(1);
        bus.redirect_valid = 1'b0;
        chk("redir_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_addr", 32'(bus.imem_addr), 32'd9);
        step(1);
        chk("redir_valid", 32'(bus.out_valid), 32'd1);
        chk("redir_pc", 32'(bus.out_pc), 32'd9);
        chk("redir_inst", bus.out_inst, 32'h109);
        drain(20);

        // Out-of-range redirect target lands on address 0
        step(2);
        for (int i = 0; i < 3; i++) exp_q.push_back(AW'(i));
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(20);
        step(1);
        bus.redirect_valid = 1'b0;
        chk("redir20_addr", 32'(bus.imem_addr), 32'd0);
        chk("redir20_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        drain(20);

        // Asynchronous reset between edges with a full buffer
        step(2);
        chk("arst_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("arst_pre_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", 32'(bus.imem_addr), 32'd0);
        chk("arst_pc", 32'(bus.out_pc), 32'd0);
        chk("arst_inst", bus.out_inst, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(1);

        // BOOT_PC=14 instance: PC wraps 15 -> 0
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        chk("wrap_busy", 32'(busy2), 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] e;
            e = AW'((14 + i) % DEPTH);
            step(1);
            chk("wrap_valid", 32'(bus2.out_valid), 32'd1);
            chk("wrap_pc", 32'(bus2.out_pc), 32'(e));
            chk("wrap_inst", bus2.out_inst, 32'h100 + 32'(e));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the word-addressed, combinational-read instruction memory.
- Owns the program counter and drives the memory address.
- Captures returned words into a 2-entry buffer and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush), start/halt control and address wrap-around.

Parameters:
- ADDR_W, `MEM_ADDR_WIDTH, PC / memory word-address width
- DEPTH, `IMEM_DEPTH, number of instruction words; PC wraps at DEPTH
- WORD_W, `WORD_WIDTH, instruction width
- BOOT_PC, 0, PC loaded at reset

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: leave IDLE/HALT and begin fetching
- halt_req  in  1  pulse: stop issuing fetches
- imem_addr  out  ADDR_W  word address to instruction memory
- imem_inst  in  WORD_W  instruction word, combinationally valid same cycle as imem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  new word address
- out_valid  out  1  out_inst/out_pc valid
- out_ready  in  1  decode accepts this cycle
- out_inst  out  WORD_W  buffered instruction
- out_pc  out  ADDR_W  address of out_inst
- busy  out  1  state==RUN

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=BOOT_PC, buffer empty.
  - out_valid=0, out_inst=0, out_pc=0, busy=0, imem_addr=BOOT_PC.
- imem_addr = pc, combinationally, at all times.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN on start=1 with halt_req=0. If start and halt_req are both 1, halt_req wins and the FSM stays IDLE.
  - RUN -> HALT on halt_req.
  - HALT -> RUN on start.
  - There is no path back to IDLE except reset.
- Fetch issue (fire): state==RUN AND no redirect AND (count<2 OR pop).
  - pop = out_valid & out_ready.
  - On fire: push {pc, imem_inst}; pc <= (pc==DEPTH-1) ? 0 : pc+1.
  - Wrap is an explicit compare, not natural overflow; DEPTH need not be a power of 2.
- Buffer: 2-entry FIFO, head drives out_inst/out_pc directly from registers.
  - out_valid = count!=0.
  - Push and pop in the same cycle keep count unchanged and preserve ordering.
  - Latency: the instruction fetched in cycle N is visible on out_* in cycle N+1.
  - Steady-state throughput is 1 instruction/cycle with out_ready held high.
- Full buffer, out_ready=0: no fire; pc, imem_addr and the buffer are held.
- Empty buffer: out_valid=0; out_inst/out_pc hold their last values. Verification must not check them while out_valid=0.
- Redirect (any state):
  - Buffer flushed (count<=0).
  - pc <= redirect_pc, or 0 if redirect_pc>=DEPTH.
  - No push that cycle.
  - A pop in the same cycle is still counted as accepted by decode, but the entry is discarded by the flush.
  - The first redirected instruction appears on out_* 2 cycles after the redirect edge.
  - Redirect in IDLE/HALT updates pc only.
- HALT:
  - No new fetches.
  - Buffered entries still drain to decode.
  - pc holds, so a resume continues from the next unfetched address.
- halt_req and redirect_valid in the same RUN cycle: both take effect (state->HALT, flush, pc<=redirect_pc).
- Reset asserted mid-operation: immediate return to reset values regardless of state or pending handshake.

Decomposition:
- The existing constants.vh holds MEM_ADDR_WIDTH, IMEM_DEPTH and WORD_WIDTH.
- Add the FSM state encodings there as `FETCH_IDLE=2'd0, `FETCH_RUN=2'd1, `FETCH_HALT=2'd2.
- One natural sub-module: fetch_buf2, a 2-entry synchronous FIFO.
  - Parameter: DATA_W = ADDR_W+WORD_W.
  - Ports: push, pop, flush, din, dout, count.
  - Precedence: flush over push/pop.

Test Plan:
- Reset/start: DEPTH=16, memory[i]=i+0x100, out_ready=1, start at cycle 2 -> out_valid rises cycle 4 with out_pc=0/out_inst=0x100, then pc 1,2,3… every cycle.
- Backpressure: out_ready=0 for 5 cycles after RUN -> count saturates at 2, imem_addr frozen at 2, out_pc stays 0. Then out_ready=1 -> out_pc sequence 0,1,2,3 with no gap or duplicate.
- Redirect: redirect_valid with redirect_pc=9 while out_pc=3 valid -> out_valid=0 next cycle, then out_pc=9, inst 0x109. Addresses 4/5 are never presented.
- Wrap: start with BOOT_PC=14, DEPTH=16 -> out_pc sequence 14,15,0,1. Redirect_pc=20 -> out_pc=0.
- Halt/resume: halt_req while 2 entries are buffered -> both drain, then out_valid=0 and busy=0. start -> fetch resumes at the held pc. start+halt_req in IDLE -> stays IDLE.
- Async reset mid-run: reset_n low between clock edges -> out_valid=0, busy=0 and imem_addr=BOOT_PC immediately, without waiting for a clk edge.
